spi_cmd_arbiter: RTL

Round-robin command arbiter and sequencer sitting in front of `SPI_driver`, in the `clk` (~40 MHz) domain. Two requesters share the single chip SPI port: port 0 is the register-bus path, port 1 is an automatic readback/monitor engine. The arbiter accepts one command at a time and drives the driver's command inputs with a one-cycle `new_command` pulse. It waits for the matching completion flag, enforces a timeout with driver reset recovery, and returns a per-requester response pulse.

---
 rtl/spi_cmd_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_cmd_arbiter.sv
// Two-requester round-robin command arbiter in front of SPI_driver.
// Issues one command at a time, waits for a fresh completion edge, and recovers the driver after a timeout.
`timescale 1ns/1ps

module spi_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_is_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [15:0] req_num,
    output logic [1:0]  resp_valid,
    output logic        resp_timeout,
    output logic        busy,
    output logic        grant_id,
    output logic        new_command,
    output logic        is_write,
    output logic [7:0]  write_register_addr,
    output logic [7:0]  write_data,
    output logic [7:0]  start_read_register_addr,
    output logic [7:0]  num_regs_to_read,
    output logic        drv_rst,
    input  logic        write_complete,
    input  logic        read_complete
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > RECOVER_CYCLES) ? TIMEOUT_CYCLES : RECOVER_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RECOVER, RESP} state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            last_grant_r;
    logic            prev_flag_r;
    logic            grant_s, transfer_s, gid_s, sel_flag_s, edge_s, resp_to_s;
    logic [3:0]      lane_s;

    // Round-robin grant and the combinational accept handshake
    always_comb begin
        if (req_valid[~last_grant_r]) begin
            grant_s = ~last_grant_r;
        end else begin
            grant_s = last_grant_r;
        end
        lane_s     = {grant_s, 3'b000};
        transfer_s = (state_r == IDLE) && req_valid[grant_s];
        gid_s      = transfer_s ? grant_s : grant_id;
        req_ready  = 2'b00;
        if (transfer_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = 2'b00;
        end
    end

    // A stale high level was captured in ISSUE, so only a genuine 0->1 transition counts
    always_comb begin
        sel_flag_s = is_write ? write_complete : read_complete;
        edge_s     = sel_flag_s & ~prev_flag_r;
    end

    // Next-state, timeout and recovery counting
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        resp_to_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (transfer_s) begin
                    if (!req_is_write[grant_s] && (req_num[lane_s +: 8] == 8'd0)) begin
                        state_s = RESP;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                cnt_s   = {CW{1'b0}};
                state_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (edge_s) begin
                    state_s = RESP;
                end else if (cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = RECOVER;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            RECOVER: begin
                if (cnt_r == CW'(RECOVER_CYCLES - 1)) begin
                    resp_to_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, registered outputs and latched command fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r                  <= IDLE;
            cnt_r                    <= {CW{1'b0}};
            last_grant_r             <= 1'b1;
            prev_flag_r              <= 1'b0;
            resp_valid               <= 2'b00;
            resp_timeout             <= 1'b0;
            busy                     <= 1'b0;
            grant_id                 <= 1'b0;
            new_command              <= 1'b0;
            is_write                 <= 1'b0;
            write_register_addr      <= 8'd0;
            write_data               <= 8'd0;
            start_read_register_addr <= 8'd0;
            num_regs_to_read         <= 8'd0;
            drv_rst                  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            busy         <= (state_s != IDLE);
            new_command  <= (state_s == ISSUE);
            drv_rst      <= (state_s == RECOVER);
            resp_timeout <= (state_s == RESP) && resp_to_s;
            resp_valid   <= (state_s == RESP) ? (gid_s ? 2'b10 : 2'b01) : 2'b00;
            if ((state_r == ISSUE) || (state_r == WAIT_DONE)) begin
                prev_flag_r <= sel_flag_s;
            end
            if (transfer_s) begin
                grant_id                 <= grant_s;
                last_grant_r             <= grant_s;
                is_write                 <= req_is_write[grant_s];
                write_register_addr      <= req_addr[lane_s +: 8];
                start_read_register_addr <= req_addr[lane_s +: 8];
                write_data               <= req_wdata[lane_s +: 8];
                num_regs_to_read         <= req_num[lane_s +: 8];
            end
        end
    end

endmodule
